// File: rtl/v850_pkg.sv
// Shared types and helpers for the V850 fetch stage: address type, instruction
// length encoding and the request state machine encoding.
package v850_pkg;

  typedef logic [31:0] v850_addr_t;

  localparam logic INST_LEN_16 = 1'b0;
  localparam logic INST_LEN_32 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_REQ_DROP = 2'd2
  } req_state_e;

  // A first halfword with bits [10:9] set starts a 32-bit (or unsupported 48-bit) form.
  function automatic logic v850_is_32bit(logic [15:0] hw);
    return hw[10:9] == 2'b11;
  endfunction

endpackage

// File: rtl/v850_fetch_sequencer_if.sv
// Bundles the instruction-memory, redirect and decoder handshakes of the fetch stage.
interface v850_fetch_sequencer_if;
  import v850_pkg::*;

  logic        imem_req;
  v850_addr_t  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        redirect_valid;
  v850_addr_t  redirect_pc;

  logic        inst_valid;
  logic [31:0] inst;
  v850_addr_t  inst_pc;
  logic        inst_len;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, inst_len,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, inst_len,
    output inst_ready
  );

endinterface

// File: rtl/v850_hw_fifo.sv
// Four-entry halfword FIFO with 0/1/2 push and pop per cycle, flush, and
// head / head+1 read ports for instruction assembly.
module v850_hw_fifo (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       push_n,
  input  logic [1:0][15:0] push_data,
  input  logic [1:0]       pop_n,
  output logic [15:0]      head,
  output logic [15:0]      head1,
  output logic [2:0]       count
);

  logic [3:0][15:0] mem_q, mem_d;
  logic [1:0]       rd_q, rd_d, wr;
  logic [2:0]       cnt_q, cnt_d;

  // Write slot is the first free one before this cycle's pop; popped slots are
  // still read combinationally this cycle, so overwriting them is safe.
  assign wr = rd_q + cnt_q[1:0];

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_n != 2'd0) mem_d[wr]        = push_data[0];
      if (push_n == 2'd2) mem_d[wr + 2'd1] = push_data[1];
      rd_d  = rd_q + pop_n;
      cnt_d = cnt_q - {1'b0, pop_n} + {1'b0, push_n};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign head1 = mem_q[rd_q + 2'd1];
  assign count = cnt_q;

endmodule

// File: rtl/v850_fetch_sequencer.sv
// V850 fetch stage: word fetch over req/ack, halfword buffering, 16/32-bit
// instruction assembly, fetch PC ownership and redirect handling.
module v850_fetch_sequencer
  import v850_pkg::*;
#(
  parameter v850_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  v850_fetch_sequencer_if.master  bus
);

  req_state_e state_q, state_d;
  v850_addr_t addr_q, addr_d, pc_q, pc_d, pend_q, pend_d;
  logic       drop_q, drop_d;

  logic [2:0]       cnt, proj;
  logic [15:0]      head, head1;
  logic [1:0]       push_n, pop_n;
  logic [1:0][15:0] push_data;
  logic             head32, inst_vld, ack, xfer, redir, holding;

  assign head32   = v850_is_32bit(head);
  assign inst_vld = head32 ? (cnt >= 3'd2) : (cnt != 3'd0);
  assign ack      = (state_q != ST_IDLE) && bus.imem_ack;
  assign xfer     = inst_vld && bus.inst_ready;
  assign redir    = bus.redirect_valid;
  assign holding  = (state_q != ST_IDLE) && !ack;

  // Redirect voids any consume and push this cycle; REQ_DROP acks are discarded.
  always_comb begin
    pop_n     = 2'd0;
    push_n    = 2'd0;
    push_data = {bus.imem_rdata[31:16], bus.imem_rdata[15:0]};
    if (drop_q) push_data[0] = bus.imem_rdata[31:16];
    if (!redir) begin
      if (xfer) pop_n = head32 ? 2'd2 : 2'd1;
      if (ack && state_q == ST_REQ) push_n = drop_q ? 2'd1 : 2'd2;
    end
    proj = cnt - {1'b0, pop_n} + {1'b0, push_n};
  end

  v850_hw_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .head      (head),
    .head1     (head1),
    .count     (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (redir || proj <= 3'd2) state_d = ST_REQ;
      ST_REQ:      if (redir)                 state_d = ack ? ST_REQ : ST_REQ_DROP;
                   else if (ack && proj > 3'd2) state_d = ST_IDLE;
      ST_REQ_DROP: if (ack)                   state_d = ST_REQ;
      default:                                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    pc_d   = pc_q;
    pend_d = pend_q;
    drop_d = drop_q;
    if (redir) begin
      pc_d = bus.redirect_pc & ~32'h1;
      if (holding) begin
        pend_d = bus.redirect_pc;
      end else begin
        addr_d = bus.redirect_pc & ~32'h3;
        drop_d = bus.redirect_pc[1];
      end
    end else begin
      if (xfer) pc_d = pc_q + (head32 ? 32'd4 : 32'd2);
      if (ack) begin
        if (state_q == ST_REQ_DROP) begin
          addr_d = pend_q & ~32'h3;
          drop_d = pend_q[1];
        end else begin
          addr_d = addr_q + 32'd4;
          drop_d = 1'b0;
        end
      end
    end
  end

  // The drop flag comes out of reset set when RESET_PC points at an upper halfword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= RESET_PC & ~32'h3;
      pc_q   <= RESET_PC & ~32'h1;
      pend_q <= '0;
      drop_q <= RESET_PC[1];
    end else begin
      addr_q <= addr_d;
      pc_q   <= pc_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  assign bus.imem_req   = (state_q != ST_IDLE);
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = inst_vld;
  assign bus.inst       = head32 ? {head1, head} : {16'h0000, head};
  assign bus.inst_pc    = pc_q;
  assign bus.inst_len   = head32 ? INST_LEN_32 : INST_LEN_16;

endmodule

// File: tb/tb_v850_fetch_sequencer.sv
// Directed and randomized bench for v850_fetch_sequencer; the expected
// instruction stream is read straight from a sparse memory image at the model PC.
`timescale 1ns/1ps
module tb_v850_fetch_sequencer;
  import v850_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v850_fetch_sequencer_if bus();
  v850_fetch_sequencer #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] mem [logic [31:0]];
  int ack_pct   = 100;
  int ready_pct = 100;
  logic [31:0] model_pc  = 32'h0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] acked_q[$];
  logic [31:0] xpc_q[$];
  logic [31:0] xinst_q[$];
  logic        xlen_q[$];
  int nx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // One clock: called at a negedge, checks, drives inputs, returns at next negedge.
  task automatic cyc(input bit rd, input logic [31:0] rpc);
    bit a, r, e32;
    logic [15:0] h;
    logic [31:0] ei;
    if (prev_hold) begin
      chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
      chk("addr_hold", bus.imem_addr, prev_addr);
    end
    if (bus.imem_req) chk("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
    a = bus.imem_req && ($urandom_range(99) < ack_pct);
    r = ($urandom_range(99) < ready_pct);
    bus.imem_ack       = a;
    bus.imem_rdata     = a ? mem_rd(bus.imem_addr) : $urandom;
    bus.inst_ready     = r;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rd ? rpc : $urandom;
    if (bus.inst_valid && r && !rd) begin
      h   = hw_at(model_pc);
      e32 = (h[10:9] == 2'b11);
      ei  = e32 ? {hw_at(model_pc + 32'd2), h} : {16'h0, h};
      chk("inst_pc", bus.inst_pc, model_pc);
      chk("inst", bus.inst, ei);
      chk("inst_len", {31'b0, bus.inst_len}, {31'b0, e32});
      xpc_q.push_back(bus.inst_pc);
      xinst_q.push_back(bus.inst);
      xlen_q.push_back(bus.inst_len);
      nx++;
      model_pc = model_pc + (e32 ? 32'd4 : 32'd2);
    end
    if (rd) model_pc = rpc & ~32'h1;
    if (a) acked_q.push_back(bus.imem_addr);
    prev_hold = bus.imem_req && !a;
    prev_addr = bus.imem_addr;
    @(negedge clk);
  endtask

  task automatic run_until_xfers(input int n, input int budget, input string tag);
    int start, k;
    start = nx;
    k = 0;
    while ((nx - start) < n && k < budget) begin
      cyc(1'b0, 32'h0);
      k++;
    end
    chk(tag, {31'b0, (nx - start) >= n}, 32'd1);
  endtask

  task automatic clear_logs();
    acked_q.delete();
    xpc_q.delete();
    xinst_q.delete();
    xlen_q.delete();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req"},   {31'b0, bus.imem_req},   32'd0);
    chk({pfx, "_addr"},  bus.imem_addr,           32'h0);
    chk({pfx, "_valid"}, {31'b0, bus.inst_valid}, 32'd0);
    chk({pfx, "_inst"},  bus.inst,                32'h0);
    chk({pfx, "_len"},   {31'b0, bus.inst_len},   32'd0);
    chk({pfx, "_pc"},    bus.inst_pc,             32'h0);
    chk({pfx, "_cnt"},   {29'b0, dut.u_fifo.count}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0; bus.inst_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[32'(i * 4)] = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state and zero-wait NOP stream
    chk_reset_vals("rst");
    rst = 1'b0;
    cyc(1'b0, 32'h0);
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    repeat (20) cyc(1'b0, 32'h0);
    chk("stream_acks", {31'b0, acked_q.size() >= 3}, 32'd1);
    if (acked_q.size() >= 3) begin
      chk("stream_addr0", acked_q[0], 32'h0);
      chk("stream_addr1", acked_q[1], 32'h4);
      chk("stream_addr2", acked_q[2], 32'h8);
    end
    if (xpc_q.size() >= 3) begin
      chk("stream_pc0", xpc_q[0], 32'h0);
      chk("stream_pc1", xpc_q[1], 32'h2);
      chk("stream_pc2", xpc_q[2], 32'h4);
    end

    // 32-bit instruction straddling two words
    mem[32'h0] = 32'h0720_0000;
    mem[32'h4] = 32'h0000_0001;
    clear_logs();
    cyc(1'b1, 32'h0);
    run_until_xfers(3, 30, "straddle_progress");
    if (xpc_q.size() >= 3) begin
      chk("straddle_pc0", xpc_q[0], 32'h0);
      chk("straddle_inst0", xinst_q[0], 32'h0);
      chk("straddle_pc1", xpc_q[1], 32'h2);
      chk("straddle_inst1", xinst_q[1], 32'h0001_0720);
      chk("straddle_len1", {31'b0, xlen_q[1]}, 32'd1);
      chk("straddle_pc2", xpc_q[2], 32'h6);
    end

    // Backpressure: buffer fills to 4 and fetch stops
    ready_pct = 0;
    repeat (10) cyc(1'b0, 32'h0);
    chk("bp_req", {31'b0, bus.imem_req}, 32'd0);
    chk("bp_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("bp_cnt", {29'b0, dut.u_fifo.count}, 32'd4);
    ready_pct = 100;
    run_until_xfers(8, 40, "bp_release");

    // Odd-halfword redirect drops the low halfword
    mem[32'h100] = 32'h0042_0720;
    clear_logs();
    cyc(1'b1, 32'h102);
    chk("odd_req", {31'b0, bus.imem_req}, 32'd1);
    chk("odd_addr", bus.imem_addr, 32'h100);
    run_until_xfers(1, 20, "odd_progress");
    if (xpc_q.size() >= 1) begin
      chk("odd_pc", xpc_q[0], 32'h102);
      chk("odd_inst", xinst_q[0], 32'h0000_0042);
    end

    // Redirect while a request is held by a stalled memory
    mem[32'h180] = 32'h0720_0720;
    cyc(1'b1, 32'h180);
    ack_pct = 0;
    chk("hold_req", {31'b0, bus.imem_req}, 32'd1);
    chk("hold_addr", bus.imem_addr, 32'h180);
    cyc(1'b1, 32'h200);
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    ack_pct = 100;
    clear_logs();
    cyc(1'b0, 32'h0);
    chk("pend_req", {31'b0, bus.imem_req}, 32'd1);
    chk("pend_addr", bus.imem_addr, 32'h200);
    run_until_xfers(2, 20, "pend_progress");
    if (xpc_q.size() >= 1) chk("pend_pc", xpc_q[0], 32'h200);

    // Redirect in the same cycle as a decoder transfer
    k = 0;
    while (!bus.inst_valid && k < 20) begin cyc(1'b0, 32'h0); k++; end
    chk("sc_valid_seen", {31'b0, bus.inst_valid}, 32'd1);
    cyc(1'b1, 32'h300);
    chk("sc_valid_after", {31'b0, bus.inst_valid}, 32'd0);

    // Asynchronous reset while a request is outstanding
    ack_pct = 0;
    k = 0;
    while (!bus.imem_req && k < 10) begin cyc(1'b0, 32'h0); k++; end
    chk("mid_req_seen", {31'b0, bus.imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst = 1'b0;
    model_pc = 32'h0;
    prev_hold = 1'b0;
    ack_pct = 100;
    run_until_xfers(4, 30, "post_rst");

    // Randomized traffic, including odd redirect targets and bit 0 set
    ack_pct = 60;
    ready_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) cyc(1'b1, 32'h1000 + 32'($urandom_range(511)));
      else                        cyc(1'b0, 32'h0);
    end
    ack_pct = 100;
    ready_pct = 100;
    run_until_xfers(4, 40, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/v850_fetch_sequencer.md
# v850_fetch_sequencer

Instruction fetch sequencer for the V850 core. It fetches 32-bit words from instruction memory over a req/ack handshake and buffers them as halfwords. It assembles 16- or 32-bit V850 instructions and hands them, with their PC, to the decoder stage over a valid/ready handshake. It owns the program counter of the fetch stage and services branch/exception redirects from the execute stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first instruction after reset. Bit 0 is ignored.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_req`  out  1: fetch request, registered.
- `imem_addr`  out  32: word-aligned fetch address; bits [1:0] are always 0.
- `imem_ack`  in  1: transfer completes on a cycle where `imem_req` and `imem_ack` are both high.
- `imem_rdata`  in  32: fetched word, valid with `imem_ack`. Bits [15:0] hold halfword at addr, bits [31:16] hold halfword at addr+2.
- `redirect_valid`  in  1: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: new PC; bit 0 ignored.
- `inst_valid`  out  1: instruction on `inst` is complete.
- `inst`  out  32: 32-bit instruction is {second hw, first hw}; a 16-bit instruction is {16'h0, hw}.
- `inst_pc`  out  32: PC of `inst`; bit 0 always 0.
- `inst_len`  out  1: 0 means 16-bit, 1 means 32-bit.
- `inst_ready`  in  1: decoder accepts; a transfer occurs when `inst_valid` and `inst_ready` are both high.

## Operation
- **Buffer:** 4-halfword FIFO, count 0..4. Each ack pushes 2 halfwords, or 1 when the low halfword is dropped.
- **Length rule:** a first halfword with hw[10:9]==2'b11 is 32-bit; all other first halfwords are 16-bit. 48-bit forms are not supported and are decoded as 32-bit.
- `inst_valid` = (count≥1 and head is 16-bit) or (count≥2 and head is 32-bit). It is driven only from registered state.
- **Consume:** on transfer, pop 1 or 2 halfwords and advance `inst_pc` by 2 or 4. Arithmetic is 32-bit and wraps modulo 2^32.
- **Request rule:** the handshake is strict. Once `imem_req` is high, it and `imem_addr` hold until ack.
  - When not holding, next `imem_req`=1 if the projected count after this cycle's push/pop is ≤2.
  - After each ack, `imem_addr` advances by 4.
- **Redirect, not holding:**
  - Flush the FIFO.
  - Set `inst_pc` = redirect_pc & ~1.
  - Next `imem_addr` = redirect_pc & ~3 and next `imem_req`=1.
  - If redirect_pc[1]=1, set a drop-low flag: on the matching ack only bits [31:16] are pushed.
- **Redirect while holding (req high, no ack):**
  - Flush the FIFO and latch the target in a pending-redirect register.
  - The in-flight ack's data is discarded.
  - On the cycle after that ack, issue the request to the pending target.
  - A redirect in the same cycle as an ack is treated as not holding; that ack's data is discarded.
- **Priority:** redirect wins over consume and push in the same cycle. A decoder transfer in that cycle is void, and `inst_valid`=0 the next cycle.
- A newer redirect overwrites an older pending one.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=RESET_PC&~3, `inst_valid`=0, `inst`=0, `inst_len`=0, `inst_pc`=RESET_PC&~1, count=0, flags cleared.
- **Reset mid-transfer:** the outstanding request is abandoned. The memory side must tolerate `imem_req` dropping on reset.
- **First request:** `imem_req` rises on the first clock edge after `rst` deasserts.
- **Fetch latency:** ack in cycle T gives buffered data and `inst_valid` in T+1.
- **Redirect latency:** redirect at T, not holding, with zero-wait memory gives `imem_req` high at T+1, ack at T+1, `inst_valid` at T+2.
- **Full FIFO (count=4):** no new request. Count never exceeds 4, because a request is issued only with ≥2 free slots, counting pops.
- **Empty FIFO:** `inst_valid`=0. A 32-bit head with count=1 waits for the next ack.
- **Straddle:** a 32-bit instruction whose halves come from two words is valid once both halves are buffered.

## Structure
- Package `v850_pkg`:
  - constant `INST_LEN_16`/`INST_LEN_32`;
  - function `v850_is_32bit(logic [15:0] hw)`;
  - `typedef logic [31:0] v850_addr_t`.
- Sub-module `v850_hw_fifo`: 4×16-bit FIFO with 0/1/2-halfword push, 0/1/2 pop, flush, head and head+1 outputs, and count. The sequencer holds the PC, request state machine and redirect logic.
- **Request state machine:** IDLE → REQ (req high) → on ack, IDLE or REQ depending on space. REQ with redirect moves to REQ_DROP; on ack, REQ_DROP → REQ at the pending target.

## Test plan
- **Reset and zero-wait stream:** reset, RESET_PC=0, memory returns 0x0000_0000-area words with ack always high.
  - `imem_addr` sequences 0, 4, 8.
  - `inst_pc` sequences 0, 2, 4 for 16-bit NOPs (0x0000).
- **32-bit straddle:** word@0 = {16'h0720, 16'h0000}, word@4 = {16'h0000, 16'h0001}, where 0x0720 has [10:9]=11.
  - Decoder sees NOP@0, then `inst`=32'h0001_0720 with `inst_len`=1 @2, then next @6.
- **Backpressure:** hold `inst_ready`=0 for 10 cycles.
  - Count saturates at 4 and `imem_req` stays 0.
  - Release `inst_ready`; no halfword is lost or duplicated.
- **Odd-halfword redirect:** redirect_pc=0x102.
  - `imem_addr`=0x100.
  - Low halfword is dropped; the first `inst_pc`=0x102 with `inst`=rdata[31:16].
- **Redirect while holding:** memory stalls ack for 3 cycles; redirect to 0x200 in cycle 1.
  - The stalled data is discarded.
  - The next request is at 0x200, and the first `inst_pc`=0x200.
- **Same-cycle redirect and consume, plus async reset mid-request:**
  - `inst_valid`=0 the cycle after the redirect.
  - `rst` asserted mid-request drops `imem_req` immediately and restores all reset values.
